// File: rtl/ft245_pkg.sv
// Shared definitions for the synchronous FT245 bridge: state encoding,
// direction constants and a counter-width helper.
package ft245_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_SETUP = 3'd1,
        ST_TX       = 3'd2,
        ST_RX_WAIT  = 3'd3,
        ST_RX       = 3'd4,
        ST_TURN     = 3'd5
    } ft_state_t;

    // Value of dir after a grant
    localparam logic DIR_TX = 1'b1;
    localparam logic DIR_RX = 1'b0;

    // Bits needed to hold values 0..max_val (never less than one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ft245_sync_arb.sv
// Synchronous FT245 bridge between the FTDI FIFO port and a TX/RX pair of
// first-word-fall-through FIFOs. TX and RX are arbitrated fairly with a
// burst limit; reads are preceded by an OE lead-in and followed by a
// one-cycle bus turnaround.
// Optional feature: define FT245_SIWU_EN to build the send-immediate flush
// (pulse ft_siwu_n after SIWU_IDLE idle cycles following TX traffic).
module ft245_sync_arb
    import ft245_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RD_WAIT   = 2,
    parameter int BURST_MAX = 64,
    parameter int SIWU_IDLE = 255
) (
    input  logic              ft_clkout,
    input  logic              rst,
    input  logic [DATA_W-1:0] ft_bus_i,
    output logic [DATA_W-1:0] ft_bus_o,
    output logic              ft_bus_oe,
    input  logic              ft_rxf_n,
    input  logic              ft_txe_n,
    output logic              ft_rd_n,
    output logic              ft_wr_n,
    output logic              ft_oe_n,
    output logic              ft_siwu_n,
    input  logic [DATA_W-1:0] tx_rdata,
    input  logic              tx_rempty,
    output logic              tx_rinc,
    output logic [DATA_W-1:0] rx_wdata,
    input  logic              rx_wfull,
    output logic              rx_winc,
    output logic              busy,
    output logic              dir
);

    localparam int BW = cnt_width(BURST_MAX - 1);
    localparam int WW = cnt_width(RD_WAIT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(RD_WAIT - 1);

    ft_state_t     state_reg, state_next;
    logic          dir_reg, dir_next;
    logic [BW-1:0] burst_reg, burst_next;
    logic [WW-1:0] wait_reg, wait_next;
    logic          tx_req, rx_req, burst_end, grant;

    assign tx_req    = !ft_txe_n && !tx_rempty;
    assign rx_req    = !ft_rxf_n && !rx_wfull;
    assign burst_end = (burst_reg == BURST_LAST);

    assign ft_bus_o = tx_rdata;
    assign rx_wdata = ft_bus_i;
    assign busy     = (state_reg != ST_IDLE);
    assign dir      = dir_reg;

    // A word moves only when the strobe and the FTDI flag are both low
    assign tx_rinc = !ft_wr_n && !ft_txe_n;
    assign rx_winc = !ft_rd_n && !ft_rxf_n;

    // Strobe decode from state and live FIFO flags, so full/empty gate the
    // strobe in the same cycle
    always_comb begin
        ft_bus_oe = 1'b0;
        ft_wr_n   = 1'b1;
        ft_rd_n   = 1'b1;
        ft_oe_n   = 1'b1;
        case (state_reg)
            ST_TX_SETUP: ft_bus_oe = 1'b1;
            ST_TX: begin
                ft_bus_oe = 1'b1;
                ft_wr_n   = tx_rempty;
            end
            ST_RX_WAIT:  ft_oe_n = (wait_reg != WAIT_LAST);
            ST_RX: begin
                ft_oe_n = 1'b0;
                ft_rd_n = rx_wfull;
            end
            default: ;
        endcase
    end

    // Arbitration, burst accounting and state sequencing
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        burst_next = burst_reg;
        wait_next  = wait_reg;
        grant      = 1'b0;
        if ((tx_rinc || rx_winc) && !burst_end) begin
            burst_next = burst_reg + 1'b1;
        end
        case (state_reg)
            ST_IDLE: begin
                // On a tie the direction not served last wins
                if (tx_req && (!rx_req || dir_reg == DIR_RX)) begin
                    state_next = ST_TX_SETUP;
                    dir_next   = DIR_TX;
                    burst_next = '0;
                    grant      = 1'b1;
                end else if (rx_req) begin
                    state_next = ST_RX_WAIT;
                    dir_next   = DIR_RX;
                    burst_next = '0;
                    wait_next  = '0;
                    grant      = 1'b1;
                end
            end
            ST_TX_SETUP: state_next = tx_req ? ST_TX : ST_IDLE;
            ST_TX: begin
                if (!tx_req || (tx_rinc && burst_end && rx_req)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RX_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    state_next = ST_RX;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            ST_RX: begin
                if (!rx_req || (rx_winc && burst_end && tx_req)) begin
                    state_next = ST_TURN;
                end
            end
            ST_TURN: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Core state register
    always_ff @(posedge ft_clkout) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            dir_reg   <= DIR_RX;
            burst_reg <= '0;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            burst_reg <= burst_next;
            wait_reg  <= wait_next;
        end
    end

`ifdef FT245_SIWU_EN
    localparam int IW = cnt_width(SIWU_IDLE);
    localparam logic [IW-1:0] IDLE_LAST = IW'(SIWU_IDLE);

    logic [IW-1:0] idle_reg, idle_next;
    logic          sent_reg, sent_next;
    logic          siwu_fire;

    // Counter only reaches its limit after uninterrupted idle, so the
    // pulse always lands in IDLE
    assign siwu_fire = (idle_reg == IDLE_LAST);
    assign ft_siwu_n = !siwu_fire;

    // Idle-with-TX-drained timer; restarts whenever the condition breaks
    always_comb begin
        idle_next = '0;
        sent_next = sent_reg || tx_rinc;
        if (siwu_fire) begin
            sent_next = 1'b0;
        end else if (state_reg == ST_IDLE && !grant && tx_rempty && sent_reg) begin
            idle_next = idle_reg + 1'b1;
        end
    end

    // Send-immediate timer registers
    always_ff @(posedge ft_clkout) begin
        if (rst) begin
            idle_reg <= '0;
            sent_reg <= 1'b0;
        end else begin
            idle_reg <= idle_next;
            sent_reg <= sent_next;
        end
    end
`else
    // Flush disabled: held inactive; SIWU_IDLE has no effect in this build
    assign ft_siwu_n = 1'b1 | (SIWU_IDLE == 0);
`endif

endmodule

// File: tb/tb_ft245_sync_arb.sv
// Scoreboard bench for ft245_sync_arb: a driver models the TX FIFO, the
// RX FIFO full flag and the FTDI host; a negedge monitor checks every
// transferred word against queues filled at issue time, plus the bus
// protocol rules, burst alternation and latencies.
module tb_ft245_sync_arb;

    localparam int DATA_W    = 8;
    localparam int RD_WAIT   = 2;
    localparam int BURST_MAX = 4;
    localparam int SIWU_IDLE = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] ft_bus_i, ft_bus_o, tx_rdata, rx_wdata;
    logic ft_bus_oe, ft_rxf_n, ft_txe_n, ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n;
    logic tx_rempty, tx_rinc, rx_wfull, rx_winc, busy, dir;

    ft245_sync_arb #(
        .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .BURST_MAX(BURST_MAX), .SIWU_IDLE(SIWU_IDLE)
    ) dut (
        .ft_clkout(clk), .rst(rst),
        .ft_bus_i(ft_bus_i), .ft_bus_o(ft_bus_o), .ft_bus_oe(ft_bus_oe),
        .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .ft_oe_n(ft_oe_n), .ft_siwu_n(ft_siwu_n),
        .tx_rdata(tx_rdata), .tx_rempty(tx_rempty), .tx_rinc(tx_rinc),
        .rx_wdata(rx_wdata), .rx_wfull(rx_wfull), .rx_winc(rx_winc),
        .busy(busy), .dir(dir)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_no = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Model FIFOs seen by the DUT and expected-output scoreboards
    logic [7:0] tx_fifo[$];
    logic [7:0] host_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    // Log of completed transfers: direction (1 = TX) and edge number
    bit         log_dir[$];
    int         log_edge[$];

    bit pop_tx = 1'b0, pop_rx = 1'b0;
    bit stall_e = 1'b0, stall_txe = 1'b0, stall_rxf = 1'b0, stall_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic drive();
        tx_rempty = (tx_fifo.size() == 0) || stall_e;
        tx_rdata  = (tx_fifo.size() != 0) ? tx_fifo[0] : 8'h00;
        ft_txe_n  = stall_txe;
        ft_rxf_n  = (host_q.size() == 0) || stall_rxf;
        ft_bus_i  = (host_q.size() != 0) ? host_q[0] : 8'($urandom);
        rx_wfull  = stall_full;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_tx && tx_fifo.size() > 0) void'(tx_fifo.pop_front());
        if (pop_rx && host_q.size() > 0) void'(host_q.pop_front());
        pop_tx = 1'b0;
        pop_rx = 1'b0;
        drive();
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_fifo.push_back(b);
        exp_tx.push_back(b);
    endtask

    task automatic push_host(input logic [7:0] b);
        host_q.push_back(b);
        exp_rx.push_back(b);
    endtask

    task automatic clear_log();
        log_dir.delete();
        log_edge.delete();
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k = 0;
        while (log_dir.size() < n && k < budget) begin
            step();
            k++;
        end
        check(name, log_dir.size(), n);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_tx.size() + exp_rx.size()) != 0 && k < budget) begin
            step();
            k++;
        end
        check(name, exp_tx.size() + exp_rx.size(), 0);
    endtask

    // Monitor: protocol rules and scoreboard comparison of every word
    initial begin
        bit prev_rst = 1'b0, prev_oe_n = 1'b1, prev_rd_n = 1'b1, prev_bus_oe = 1'b0;
        bit tx_acc, rx_acc;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (prev_rst)
                check("reset_idle", {busy, ft_wr_n, ft_rd_n, ft_oe_n, ft_bus_oe, tx_rinc, rx_winc}, 7'b0111000);
            if (!busy)
                check("idle_strobes", {ft_wr_n, ft_rd_n, ft_oe_n, ft_bus_oe, tx_rinc, rx_winc}, 6'b111000);
            if (!ft_oe_n) check("no_contention", ft_bus_oe, 1'b0);
            if (tx_rempty) check("wr_on_empty", ft_wr_n, 1'b1);
            if (rx_wfull) check("rd_on_full", ft_rd_n, 1'b1);
            if (!ft_rd_n && prev_rd_n) check("oe_before_rd", prev_oe_n, 1'b0);
            if (ft_bus_oe && !prev_bus_oe) begin
                check("turnaround", prev_oe_n, 1'b1);
                check("dir_tx", dir, 1'b1);
            end
            if (!ft_oe_n && prev_oe_n) check("dir_rx", dir, 1'b0);
`ifndef FT245_SIWU_EN
            check("siwu_tied", ft_siwu_n, 1'b1);
`endif
            tx_acc = !ft_wr_n && !ft_txe_n;
            rx_acc = !ft_rd_n && !ft_rxf_n;
            if (tx_acc || tx_rinc) check("tx_pop_qual", tx_rinc, tx_acc);
            if (rx_acc || rx_winc) check("rx_push_qual", rx_winc, rx_acc);
            if (rx_winc) check("push_when_full", rx_wfull, 1'b0);
            pop_tx = tx_rinc;
            pop_rx = rx_acc;
            if (tx_acc) begin
                if (exp_tx.size() == 0) begin
                    check("tx_extra", 1, 0);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_data", ft_bus_o, e);
                    $display("tx word %02h at edge %0d", ft_bus_o, edge_no + 1);
                end
                log_dir.push_back(1'b1);
                log_edge.push_back(edge_no + 1);
            end
            if (rx_winc) begin
                if (exp_rx.size() == 0) begin
                    check("rx_extra", 1, 0);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_data", rx_wdata, e);
                    $display("rx word %02h at edge %0d", rx_wdata, edge_no + 1);
                end
                log_dir.push_back(1'b0);
                log_edge.push_back(edge_no + 1);
            end
            prev_rst    = rst;
            prev_oe_n   = ft_oe_n;
            prev_rd_n   = ft_rd_n;
            prev_bus_oe = ft_bus_oe;
        end
    end

    // Stimulus
    initial begin
        int m;
        int k;
        rst = 1'b1;
        drive();
        repeat (3) step();
        rst = 1'b0;
        drive();
        repeat (2) step();

        // Both directions saturated: 4-word bursts alternating, TX first
        clear_log();
        for (int i = 0; i < 16; i++) begin
            push_tx(8'(8'h40 + i));
            push_host(8'(8'h80 + i));
        end
        drive();
        wait_log("sat_count", 32, 300);
        for (int i = 0; i < 32 && i < log_dir.size(); i++)
            check("burst_dir", log_dir[i], ((i / 4) % 2) == 0);
        repeat (4) step();

        // TX latency: first word two edges after the request edge
        clear_log();
        m = edge_no;
        for (int i = 0; i < 3; i++) push_tx(8'(8'hA0 + i));
        drive();
        wait_log("tx_lat_count", 3, 50);
        if (log_edge.size() >= 2) begin
            check("tx_first_edge", log_edge[0], m + 3);
            check("tx_second_edge", log_edge[1], m + 4);
        end
        repeat (4) step();

        // RX latency: first push RD_WAIT+1 edges after the request edge
        clear_log();
        m = edge_no;
        for (int i = 0; i < 5; i++) push_host(8'(8'hB0 + i));
        drive();
        wait_log("rx_lat_count", 5, 50);
        if (log_edge.size() >= 5) begin
            check("rx_first_edge", log_edge[0], m + 1 + RD_WAIT + 1);
            check("rx_last_edge", log_edge[4], m + 1 + RD_WAIT + 5);
        end
        repeat (4) step();

        // RX FIFO fills after two of six bytes
        clear_log();
        for (int i = 0; i < 6; i++) push_host(8'(8'hC0 + i));
        drive();
        k = 0;
        while (log_dir.size() < 2 && k < 50) begin
            step();
            k++;
        end
        stall_full = 1'b1;
        drive();
        repeat (5) step();
        check("full_hold", log_dir.size(), 2);
        stall_full = 1'b0;
        drive();
        wait_log("full_resume", 6, 50);
        repeat (4) step();

        // Reset in the middle of a 10-word TX burst, then resume
        clear_log();
        for (int i = 0; i < 10; i++) push_tx(8'(8'h10 + i));
        drive();
        k = 0;
        while (log_dir.size() < 4 && k < 50) begin
            step();
            k++;
        end
        rst = 1'b1;
        drive();
        repeat (2) step();
        rst = 1'b0;
        drive();
        drain("rst_resume", 60);
        repeat (4) step();

        // 0x01..0x20 with TXE high for three cycles at word 7
        clear_log();
        for (int i = 1; i <= 32; i++) push_tx(8'(i));
        drive();
        k = 0;
        while (log_dir.size() < 6 && k < 50) begin
            step();
            k++;
        end
        stall_txe = 1'b1;
        drive();
        repeat (3) step();
        stall_txe = 1'b0;
        drive();
        wait_log("tx32_count", 32, 200);
        repeat (4) step();

        // Randomised traffic with flag stalls and occasional reset
        for (int c = 0; c < 400; c++) begin
            if (tx_fifo.size() < 8 && $urandom_range(0, 2) == 0) push_tx(8'($urandom));
            if (host_q.size() < 8 && $urandom_range(0, 2) == 0) push_host(8'($urandom));
            stall_e    = ($urandom_range(0, 9) == 0);
            stall_txe  = ($urandom_range(0, 7) == 0);
            stall_rxf  = ($urandom_range(0, 9) == 0);
            stall_full = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 149) == 0);
            drive();
            step();
        end
        stall_e = 1'b0;
        stall_txe = 1'b0;
        stall_rxf = 1'b0;
        stall_full = 1'b0;
        rst = 1'b0;
        drive();
        drain("final_drain", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ft245_sync_arb.md
# ft245_sync_arb

Parametrised synchronous FT245 bridge between an FTDI FIFO port and a pair of first-word-fall-through FIFOs (TX toward host, RX from host). Successor to the fixed 8-bit bridge, it adds:
- configurable bus width and read turn-around;
- exact per-word transfer qualification on every clock;
- fair TX/RX arbitration with a burst limit;
- a one-cycle bus turnaround after reads;
- optional send-immediate flush.

It sits between the pad buffers and the system FIFOs, clocked by the FTDI-supplied clock.

## Interface
Parameters:
- DATA_W, 8: FT bus and FIFO data width.
- RD_WAIT, 2: cycles spent in RX_WAIT before reading (≥1).
- BURST_MAX, 64: words per grant before yielding to a pending opposite direction (≥1).
- SIWU_IDLE, 255: idle cycles before a send-immediate pulse (used only with FT245_SIWU_EN).

Ports (one clock; reset is synchronous, active-high):
- ft_clkout, in, 1: FTDI clock, sole clock.
- rst, in, 1: synchronous active-high reset.
- ft_bus_i, in, DATA_W: bus value from pads.
- ft_bus_o, out, DATA_W: bus drive value, equal to tx_rdata.
- ft_bus_oe, out, 1: pad output enable, high only in TX_SETUP and TX.
- ft_rxf_n, in, 1: host data available, active-low.
- ft_txe_n, in, 1: FTDI can accept data, active-low.
- ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n, out, 1 each: FTDI strobes, active-low.
- tx_rdata, in, DATA_W: TX FIFO head word.
- tx_rempty, in, 1: TX FIFO empty.
- tx_rinc, out, 1: TX FIFO pop.
- rx_wdata, out, DATA_W: equals ft_bus_i.
- rx_wfull, in, 1: RX FIFO full.
- rx_winc, out, 1: RX FIFO push.
- busy, out, 1: state ≠ IDLE.
- dir, out, 1: last granted direction; 1 = TX.

## Operation
- States: IDLE, TX_SETUP, TX, RX_WAIT, RX, TURN. Registered state; strobes are decoded combinationally from state and live inputs.
- Request flags:
  - tx_req = !ft_txe_n && !tx_rempty.
  - rx_req = !ft_rxf_n && !rx_wfull.
- IDLE arbitration:
  - Only one request set: go to its path.
  - Both set: grant the direction opposite to dir.
  - Every grant updates dir and clears burst_cnt.
- TX path:
  - IDLE → TX_SETUP for one cycle: bus driven, ft_wr_n high.
  - TX_SETUP → TX if tx_req, else IDLE.
  - In TX: ft_wr_n = tx_rempty. tx_rinc = !ft_wr_n && !ft_txe_n. A word counts only when both are low at the same edge, so no word is lost or duplicated when TXE rises.
  - Leave TX → IDLE at the first edge with !tx_req, or with burst_cnt == BURST_MAX-1 on an accepted word while rx_req.
- RX path:
  - IDLE → RX_WAIT, held RD_WAIT cycles via wait counter.
  - ft_oe_n is low in the final RX_WAIT cycle and throughout RX.
  - In RX: ft_rd_n = rx_wfull. rx_winc = !ft_rd_n && !ft_rxf_n.
  - Leave RX → TURN at the first edge with !rx_req, or on the burst limit while tx_req.
  - TURN lasts one cycle with oe high and bus not driven, then IDLE.
- burst_cnt: counts accepted words, saturates at BURST_MAX-1. With no competing request the burst continues unbounded.
- ft_siwu_n is constant 1 unless FT245_SIWU_EN is defined.

## Timing
- Reset state: IDLE; dir = 0, so TX wins the first tie.
  - burst_cnt, wait counter and idle counter are 0.
  - Strobes deassert from the first edge at which rst is sampled high; rst overrides any state mid-burst.
  - With state IDLE: all strobes high, ft_bus_oe 0, tx_rinc 0, rx_winc 0.
- TX latency: tx_req at edge N → TX_SETUP during N..N+1 → first word accepted at edge N+2 when tx_req holds.
- RX latency: rx_req at edge N → first push at edge N+RD_WAIT+1. Sustained throughput is one word per clock.
- Full/empty:
  - tx_rempty or rx_wfull raised mid-burst deasserts the strobe in the same cycle (combinational). No push or pop occurs that cycle, and the state exits at that edge.
- Turnaround: the bus is never driven by the FPGA while ft_oe_n is low; there is at least one cycle between an RX exit and TX_SETUP.

## Configuration
- FT245_SIWU_EN defined:
  - The idle counter increments in IDLE while tx_rempty is set and at least one TX word has been accepted since the last flush.
  - When it reaches SIWU_IDLE, ft_siwu_n is low for exactly one cycle; the counter and the flag then clear.
  - Any grant clears the counter.
- Not defined: ft_siwu_n is tied 1, and the counter and flag are not synthesised.

## Structure
- Package ft245_pkg holds:
  - state encoding localparams;
  - DIR_TX/DIR_RX constants;
  - a helper for counter width.
- Sub-module ft245_iobuf: DATA_W-wide SB_IO tristate wrapper under SYNTHESIS, with a behavioural tristate model otherwise. Instantiated at top level, not inside this block.

## Test plan
- Reset mid-TX burst of 10 words:
  - all strobes high from the reset edge;
  - exactly the words with wr_n&txe_n low were popped;
  - after release, TX resumes from the next FIFO word.
- TX of 0x01..0x20 with ft_txe_n high for 3 cycles at word 7: host receives 0x01..0x20 in order, no gaps or repeats; tx_rinc count = 32.
- RX with RD_WAIT=2, host offers 5 bytes:
  - ft_oe_n low one cycle before ft_rd_n;
  - first rx_winc at edge N+3;
  - 5 pushes;
  - TURN observed before the next TX_SETUP.
- Both directions saturated, BURST_MAX=4: bursts alternate TX,RX,TX... of exactly 4 words; first grant goes to TX.
- rx_wfull asserted after 2 of 6 RX bytes: ft_rd_n high in that same cycle, 2 pushes, and the remaining 4 are delivered after full clears.
- FT245_SIWU_EN, SIWU_IDLE=8: one TX word then idle → single-cycle ft_siwu_n low 8 cycles after entering IDLE with TX empty, and no repeat pulse without new TX.
